// File: rtl/uart_rx_apb_ctrl_pkg.sv
// Shared definitions for the UART receive-path APB controller.
//  - DATA_WIDTH         : width of a received character
//  - UART_*_ADDR        : APB byte addresses of the four registers
//  - CTRL_* / STAT_*    : bit positions inside CTRL and STATUS
//  - reg_sel_e          : decoded register select (word index paddr[3:2])
package uart_rx_apb_ctrl_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [3:0] UART_CTRL_ADDR = 4'h0;
  localparam logic [3:0] UART_STAT_ADDR = 4'h4;
  localparam logic [3:0] UART_DATA_ADDR = 4'h8;
  localparam logic [3:0] UART_ECNT_ADDR = 4'hC;

  localparam int CTRL_RX_EN       = 0;
  localparam int CTRL_IRQ_DATA_EN = 1;
  localparam int CTRL_IRQ_ERR_EN  = 2;
  localparam int CTRL_FLUSH       = 3;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_RX_ERR    = 3;

  typedef enum logic [1:0] {
    REG_CTRL = UART_CTRL_ADDR[3:2],
    REG_STAT = UART_STAT_ADDR[3:2],
    REG_DATA = UART_DATA_ADDR[3:2],
    REG_ECNT = UART_ECNT_ADDR[3:2]
  } reg_sel_e;

  // Every word index of the 4-bit address space maps to a register.
  function automatic reg_sel_e decode_word(input logic [1:0] word);
    return reg_sel_e'(word);
  endfunction

endpackage

// File: rtl/uart_rx_apb_ctrl_rx_sync_fifo.sv
// rx_sync_fifo: DEPTH x WIDTH synchronous FIFO with first-word-fall-through head.
//  clk, rst_n : clock, asynchronous active-low reset
//  push, din  : write request and data (accepted when not full, or when popping)
//  pop        : read request (ignored when empty)
//  flush      : empties the FIFO; a coincident push/pop is discarded
//  head       : current oldest entry (valid when empty=0)
//  count      : occupancy 0..DEPTH; full / empty flags
module rx_sync_fifo
  import uart_rx_apb_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = occ;

endmodule

// File: rtl/uart_rx_apb_ctrl.sv
// uart_rx_apb_ctrl: APB3 slave controlling the UART receive path.
//  APB  : psel, penable, pwrite, paddr[3:0], pwdata[31:0] in; prdata, pready(=1), pslverr out
//  RX   : rx_data/rx_done (received byte), rx_error (error pulse) in; rx_en out
//  irq  : registered level interrupt (data available / error conditions)
// Registers: CTRL 0x0, STATUS 0x4 (W1C stickies), DATA 0x8 (read pops), ERRCNT 0xC.
module uart_rx_apb_ctrl
  import uart_rx_apb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ERRCNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  rx_error,
  output logic                  rx_en,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e              sel;
  logic                  access, wr, rd;
  logic                  flush_req, fifo_pop, push_req, overrun_set, err_evt;
  logic                  clr_overrun, clr_rx_err;
  logic [2:0]            ctrl;
  logic                  overrun, rx_err;
  logic [ERRCNT_W-1:0]   errcnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  unused_bits;

  assign sel    = decode_word(paddr[3:2]);
  assign access = psel & penable;
  assign wr     = access & pwrite;
  assign rd     = access & ~pwrite;
  assign pready = 1'b1;
  assign rx_en  = ctrl[CTRL_RX_EN];

  assign flush_req   = wr && (sel == REG_CTRL) && pwdata[CTRL_FLUSH];
  assign fifo_pop    = rd && (sel == REG_DATA) && !fifo_empty;
  assign push_req    = rx_done & rx_en;
  // A byte arriving during a flush is discarded silently, not counted as overrun.
  assign overrun_set = push_req & fifo_full & ~fifo_pop & ~flush_req;
  assign err_evt     = rx_error & rx_en;
  assign clr_overrun = wr && (sel == REG_STAT) && pwdata[STAT_OVERRUN];
  assign clr_rx_err  = wr && (sel == REG_STAT) && pwdata[STAT_RX_ERR];
  assign unused_bits = ^{pwdata[31:4], paddr[1:0]};

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req & ~flush_req),
    .din   (rx_data),
    .pop   (fifo_pop),
    .flush (flush_req),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= '0;
      overrun <= 1'b0;
      rx_err  <= 1'b0;
      errcnt  <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr && sel == REG_CTRL) ctrl <= pwdata[2:0];
      // Set events take priority over a coincident W1C.
      overrun <= overrun_set | (overrun & ~clr_overrun);
      rx_err  <= err_evt | (rx_err & ~clr_rx_err);
      if (wr && sel == REG_ECNT)
        errcnt <= err_evt ? ERRCNT_W'(1) : '0;
      else if (err_evt && errcnt != '1)
        errcnt <= errcnt + 1'b1;
      irq <= (ctrl[CTRL_IRQ_DATA_EN] & ~fifo_empty) |
             (ctrl[CTRL_IRQ_ERR_EN] & (overrun | rx_err));
    end
  end

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (sel)
        REG_CTRL: if (!pwrite) prdata = 32'(ctrl);
        REG_STAT: if (!pwrite) begin
          prdata[15:8]           = 8'(fifo_count);
          prdata[STAT_NOT_EMPTY] = ~fifo_empty;
          prdata[STAT_FULL]      = fifo_full;
          prdata[STAT_OVERRUN]   = overrun;
          prdata[STAT_RX_ERR]    = rx_err;
        end
        REG_DATA: begin
          if (pwrite)          pslverr = 1'b1;
          else if (fifo_empty) pslverr = 1'b1;
          else                 prdata  = 32'(fifo_head);
        end
        REG_ECNT: if (!pwrite) prdata = 32'(errcnt);
        default: ;
      endcase
    end
  end

endmodule
